// File: rtl/lib_stim_checker_if.sv
// Bundle between the stimulus sequencer/checker and the cell library under test.
// master: the checker (drives stimulus and status, reads cell outputs and start).
// slave:  the cell library / host side.
interface lib_stim_checker_if #(
  parameter int unsigned ERR_W = 8
);
  // Run request from the host
  logic             start;
  // Cell outputs fed back to the checker
  logic             cell_nand;
  logic             cell_nor;
  logic             cell_not;
  logic             qp;
  logic             qn;
  // Stimulus nets shared by the cell instances
  logic             a;
  logic             b;
  logic             sel;
  logic             enb;
  logic             d;
  logic             ffd_clk;
  logic             ffd_clr;
  logic             ffd_pre;
  // Run status
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    input  start, cell_nand, cell_nor, cell_not, qp, qn,
    output a, b, sel, enb, d, ffd_clk, ffd_clr, ffd_pre,
    output busy, done, pass, err_cnt
  );

  modport slave (
    output start, cell_nand, cell_nor, cell_not, qp, qn,
    input  a, b, sel, enb, d, ffd_clk, ffd_clr, ffd_pre,
    input  busy, done, pass, err_cnt
  );
endinterface

// File: rtl/lib_stim_checker.sv
// Stimulus sequencer and golden checker for the nand/nor/not/mux/ffd cells.
// A run sweeps all 16 combinational vectors, then clocks the flip-flop through
// an 8-step pattern, then reports done/pass with a saturating error count.
// Every output is registered from the current FSM/counter state, so stimulus
// lags the state by one cycle; checks are scheduled through a registered strobe
// so they always land on the last cycle that the stimulus is visible.
module lib_stim_checker #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CLK_DIV     = 2,
  parameter logic [7:0]  SEQ_PATTERN = 8'b1011_0010,
  parameter int unsigned ERR_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  lib_stim_checker_if.master bus
);

  localparam int unsigned     HOLD_W    = $clog2(HOLD_CYCLES);
  localparam int unsigned     PH_W      = $clog2(2 * CLK_DIV);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_COMB, S_SEQ, S_DONE} state_t;
  typedef enum logic [1:0] {CHK_NONE, CHK_COMB, CHK_SEQ} chk_t;

  state_t            state_q, state_d;
  logic [3:0]        vec_q, vec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        step_q, step_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              run_clear;

  // Next values of the registered outputs
  logic [3:0]        stim_d;
  logic              d_d, fclk_d, clr_d, pre_d, busy_d, done_d, pass_d;
  chk_t              chk_d, chk_q;

  // Checker datapath
  logic              exp_qp;
  logic [1:0]        fails;
  logic [ERR_W+1:0]  err_sum;
  logic [ERR_W-1:0]  err_chk;

  // FSM next state, counters and next stimulus derived from the current state
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    step_d    = step_q;
    phase_d   = phase_q;
    run_clear = 1'b0;
    stim_d    = 4'h0;
    d_d       = 1'b0;
    fclk_d    = 1'b0;
    clr_d     = 1'b0;
    pre_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    chk_d     = CHK_NONE;

    case (state_q)
      S_IDLE, S_DONE: begin
        done_d = (state_q == S_DONE);
        if (bus.start) begin
          state_d   = S_COMB;
          vec_d     = 4'h0;
          hold_d    = '0;
          step_d    = 3'd0;
          phase_d   = '0;
          run_clear = 1'b1;
        end
      end

      S_COMB: begin
        busy_d = 1'b1;
        stim_d = vec_q;
        if (hold_q == HOLD_LAST) begin
          chk_d  = CHK_COMB;
          hold_d = '0;
          if (vec_q == 4'hF) begin
            state_d = S_SEQ;
            step_d  = 3'd0;
            phase_d = '0;
          end else begin
            vec_d = vec_q + 4'h1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_SEQ: begin
        busy_d = 1'b1;
        d_d    = SEQ_PATTERN[step_q];
        fclk_d = (phase_q >= PH_HIGH);
        clr_d  = (step_q == 3'd0);
        pre_d  = (step_q == 3'd4);
        if (phase_q == PH_LAST) begin
          chk_d   = CHK_SEQ;
          phase_d = '0;
          if (step_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Golden comparison of the cell outputs against the stimulus currently shown
  always_comb begin
    exp_qp = bus.ffd_clr ? 1'b0 : (bus.ffd_pre ? 1'b1 : bus.d);
    fails  = 2'd0;
    case (chk_q)
      CHK_COMB: fails = 2'(bus.cell_nand != ~(bus.a & bus.b))
                      + 2'(bus.cell_nor  != ~(bus.a | bus.b))
                      + 2'(bus.cell_not  != ~bus.a);
      CHK_SEQ:  fails = 2'(bus.qp != exp_qp)
                      + 2'(bus.qn != ~bus.qp);
      default:  fails = 2'd0;
    endcase

    err_sum = {2'b00, bus.err_cnt} + {{ERR_W{1'b0}}, fails};
    if (err_sum > {2'b00, {ERR_W{1'b1}}}) begin
      err_chk = '1;
    end else begin
      err_chk = err_sum[ERR_W-1:0];
    end

    pass_d = (state_q == S_DONE) && (err_chk == '0);
  end

  // FSM state and sequencing counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 4'h0;
      hold_q  <= '0;
      step_q  <= 3'd0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

  // Registered stimulus, status and check strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {bus.enb, bus.sel, bus.b, bus.a} <= 4'h0;
      bus.d       <= 1'b0;
      bus.ffd_clk <= 1'b0;
      bus.ffd_clr <= 1'b0;
      bus.ffd_pre <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      chk_q       <= CHK_NONE;
    end else begin
      // NOTE: non-blocking so every register here samples the pre-edge values.
      {bus.enb, bus.sel, bus.b, bus.a} <= stim_d;
      bus.d       <= d_d;
      bus.ffd_clk <= fclk_d;
      bus.ffd_clr <= clr_d;
      bus.ffd_pre <= pre_d;
      bus.busy    <= busy_d;
      bus.done    <= done_d;
      bus.pass    <= pass_d;
      chk_q       <= chk_d;
    end
  end

  // Saturating error counter, cleared when a new run is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err_cnt <= '0;
    end else if (run_clear) begin
      bus.err_cnt <= '0;
    end else begin
      bus.err_cnt <= err_chk;
    end
  end

endmodule

// File: tb/tb_lib_stim_checker.sv
// Directed bench for lib_stim_checker: ideal cells, injected cell faults,
// counter saturation on a narrow instance, mid-run reset and ignored/restart iStart.
module tb_lib_stim_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lib_stim_checker_if #(.ERR_W(8)) bus ();
  lib_stim_checker_if #(.ERR_W(2)) sbus ();

  lib_stim_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  lib_stim_checker #(.ERR_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.master)
  );

  // Fault injection controls for the main instance
  logic nand_stuck0 = 1'b0;
  logic qn_tied     = 1'b0;

  // Cell models for the main instance
  logic ffd_q;
  assign bus.cell_nand = nand_stuck0 ? 1'b0 : ~(bus.a & bus.b);
  assign bus.cell_nor  = ~(bus.a | bus.b);
  assign bus.cell_not  = ~bus.a;
  always @(posedge bus.ffd_clk or posedge bus.ffd_clr or posedge bus.ffd_pre) begin
    if (bus.ffd_clr)      ffd_q <= 1'b0;
    else if (bus.ffd_pre) ffd_q <= 1'b1;
    else                  ffd_q <= bus.d;
  end
  assign bus.qp = ffd_q;
  assign bus.qn = qn_tied ? ffd_q : ~ffd_q;

  // Narrow instance sees every cell output stuck at 0
  assign sbus.cell_nand = 1'b0;
  assign sbus.cell_nor  = 1'b0;
  assign sbus.cell_not  = 1'b0;
  assign sbus.qp        = 1'b0;
  assign sbus.qn        = 1'b0;

  // {enb,sel,b,a, d,ffd_clk,ffd_clr,ffd_pre, busy,done,pass}
  logic [10:0] outs, sat_outs;
  assign outs = {bus.enb, bus.sel, bus.b, bus.a, bus.d, bus.ffd_clk, bus.ffd_clr,
                 bus.ffd_pre, bus.busy, bus.done, bus.pass};
  assign sat_outs = {sbus.enb, sbus.sel, sbus.b, sbus.a, sbus.d, sbus.ffd_clk,
                     sbus.ffd_clr, sbus.ffd_pre, sbus.busy, sbus.done, sbus.pass};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to n edges after the accepted iStart edge
  task automatic go_to(input int n);
    while (cyc - t0 < n) tick();
  endtask

  task automatic restart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    bus.start  = 1'b0;
    sbus.start = 1'b0;
    repeat (3) tick();

    // Reset state
    check("reset_outs", outs, 11'h000);
    check("reset_err", bus.err_cnt, 0);
    check("reset_sat_outs", sat_outs, 11'h000);
    check("reset_sat_err", sbus.err_cnt, 0);
    rst = 1'b0;
    tick();

    // Test 1: ideal cells, both instances started together
    bus.start  = 1'b1;
    sbus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    sbus.start = 1'b0;
    t0 = cyc;
    check("t1_busy_lag", bus.busy, 0);
    go_to(1);
    check("t1_vec0", outs, 11'b0000_0000_100);
    go_to(5);
    check("t4_sat_first", sbus.err_cnt, 3);
    go_to(9);
    check("t4_sat_nowrap", sbus.err_cnt, 3);
    go_to(21);
    check("t1_vec5", outs, 11'b0101_0000_100);
    go_to(64);
    check("t1_vec15", outs, 11'b1111_0000_100);
    go_to(65);
    check("t1_seq0_lo", outs, 11'b0000_0010_100);
    go_to(67);
    check("t1_seq0_hi", outs, 11'b0000_0110_100);
    go_to(81);
    check("t1_seq4_pre", outs, 11'b0000_1001_100);
    go_to(96);
    check("t1_seq7_last", outs, 11'b0000_1100_100);
    go_to(97);
    check("t1_done", outs, 11'b0000_0000_011);
    check("t1_err", bus.err_cnt, 0);
    check("t4_sat_done", sat_outs, 11'b0000_0000_010);
    check("t4_sat_final", sbus.err_cnt, 3);

    // Test 2 + 6: nand stuck-at-0, restart from DONE, stray iStart during COMB
    nand_stuck0 = 1'b1;
    go_to(100);
    check("t6_done_held", bus.done, 1);
    restart();
    go_to(1);
    check("t6_restart_clear", bus.err_cnt, 0);
    check("t6_restart_busy", bus.busy, 1);
    go_to(4);
    check("t2_err_pre", bus.err_cnt, 0);
    go_to(5);
    check("t2_err_first", bus.err_cnt, 1);
    go_to(30);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    go_to(96);
    check("t6_busy_96", {bus.busy, bus.done}, 2'b10);
    go_to(97);
    check("t6_done_97", {bus.busy, bus.done}, 2'b01);
    check("t2_err", bus.err_cnt, 12);
    check("t2_pass", bus.pass, 0);

    // Test 3: qn tied to qp
    nand_stuck0 = 1'b0;
    qn_tied     = 1'b1;
    go_to(100);
    restart();
    go_to(65);
    check("t3_comb_clean", bus.err_cnt, 0);
    go_to(69);
    check("t3_first_seq", bus.err_cnt, 1);
    go_to(97);
    check("t3_err", bus.err_cnt, 8);
    check("t3_pass", {bus.done, bus.pass}, 2'b10);

    // Test 5: reset during SEQ step 3 discards the partial count
    qn_tied     = 1'b0;
    nand_stuck0 = 1'b1;
    go_to(100);
    restart();
    go_to(78);
    check("t5_err_before", bus.err_cnt, 12);
    rst = 1'b1;
    #1;
    check("t5_async_outs", outs, 11'h000);
    check("t5_async_err", bus.err_cnt, 0);
    tick();
    rst = 1'b0;
    nand_stuck0 = 1'b0;
    repeat (3) tick();
    check("t5_idle", outs, 11'h000);
    restart();
    go_to(96);
    check("t5_rerun_busy", bus.busy, 1);
    go_to(97);
    check("t5_rerun_done", outs, 11'b0000_0000_011);
    check("t5_rerun_err", bus.err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
